// File: rtl/ha_rtl_pkg.sv
// Shared constants and helpers for the ha_rtl half-adder array.
package ha_rtl_pkg;

    localparam int unsigned DefWidth = 1;
    localparam int unsigned DefCntW  = 8;

    // All-ones value for a counter of the given width (widths above 32 clamp to 32 ones).
    function automatic logic [31:0] sat_max(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/ha_rtl_bit.sv
// Single-lane half adder.
module ha_bit (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/ha_rtl.sv
// WIDTH-lane half-adder array with a saturating carry-event counter.
// Define HA_RTL_REG_OUT_EN to register s/c/out_valid; otherwise outputs are combinational.
module ha_rtl
    import ha_rtl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic             carry_any,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

    logic [WIDTH-1:0] s_raw;
    logic [WIDTH-1:0] c_raw;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_bit u_bit (
            .a (a[i]),
            .b (b[i]),
            .s (s_raw[i]),
            .c (c_raw[i])
        );
    end

    // Counting uses the raw carries so it behaves the same in both output modes.
    logic             carry_event;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign carry_event = in_valid & (|c_raw);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (carry_event && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;

`ifdef HA_RTL_REG_OUT_EN
    logic [WIDTH-1:0] s_d, s_q;
    logic [WIDTH-1:0] c_d, c_q;
    logic             valid_d, valid_q;

    always_comb begin
        s_d     = s_q;
        c_d     = c_q;
        valid_d = in_valid;
        if (in_valid) begin
            s_d = s_raw;
            c_d = c_raw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = valid_q;
`else
    assign s         = s_raw;
    assign c         = c_raw;
    assign out_valid = in_valid & ~rst;
`endif

    assign carry_any = |c;

endmodule

// File: tb/tb_ha_rtl.sv
// Self-checking bench for ha_rtl (WIDTH=4, CNT_W=2); follows HA_RTL_REG_OUT_EN if defined.
module tb_ha_rtl;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    logic          in_valid, cnt_clr;
    logic [W-1:0]  s, c;
    logic          out_valid, carry_any;
    logic [CW-1:0] carry_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    int           m_cnt;
    logic [W-1:0] m_s, m_c;
    logic         m_ov;

    ha_rtl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .cnt_clr   (cnt_clr),
        .s         (s),
        .c         (c),
        .out_valid (out_valid),
        .carry_any (carry_any),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-lane arithmetic sum of two bits: low bit is the sum, high bit the carry.
    function automatic logic [2*W-1:0] lane_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] ss, cc;
        for (int i = 0; i < W; i++) begin
            int t;
            t = int'(x[i]) + int'(y[i]);
            ss[i] = (t % 2) == 1;
            cc[i] = (t / 2) == 1;
        end
        return {cc, ss};
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_s   = '0;
        m_c   = '0;
        m_ov  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".s"}, 32'(s), 32'(m_s));
        check({tag, ".c"}, 32'(c), 32'(m_c));
        check({tag, ".ov"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".any"}, 32'(carry_any), 32'(m_c != '0));
    endtask

    task automatic step(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic vi, input logic ci);
        logic [2*W-1:0] r;
        @(negedge clk);
        a = ai; b = bi; in_valid = vi; cnt_clr = ci;
        r = lane_add(ai, bi);
        #1;
`ifndef HA_RTL_REG_OUT_EN
        m_s = r[W-1:0];
        m_c = r[2*W-1:W];
        m_ov = vi;
        check_outputs({tag, ".comb"});
`endif
        @(posedge clk);
        if (ci) m_cnt = 0;
        else if (vi && r[2*W-1:W] != '0) m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
`ifdef HA_RTL_REG_OUT_EN
        if (vi) begin
            m_s = r[W-1:0];
            m_c = r[2*W-1:W];
        end
        m_ov = vi;
`endif
        #1;
        check({tag, ".cnt"}, 32'(carry_cnt), 32'(m_cnt));
`ifdef HA_RTL_REG_OUT_EN
        check_outputs({tag, ".reg"});
`endif
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #3;
        check("rst.ov", 32'(out_valid), 32'h0);
        check("rst.cnt", 32'(carry_cnt), 32'h0);
        check("rst.s", 32'(s), 32'h0);
        check("rst.c", 32'(c), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single-lane truth table on lane 0
        step("tt00", 4'b0000, 4'b0000, 1'b1, 1'b0);
        step("tt01", 4'b0000, 4'b0001, 1'b1, 1'b0);
        step("tt10", 4'b0001, 4'b0000, 1'b1, 1'b0);
        step("tt11", 4'b0001, 4'b0001, 1'b1, 1'b0);
        step("idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
        step("clr0", 4'b0000, 4'b0000, 1'b0, 1'b1);

        // Multi-lane, no inter-lane carry
        step("w4", 4'b1100, 4'b1010, 1'b1, 1'b0);
        step("clr1", 4'b0000, 4'b0000, 1'b0, 1'b1);

        // Saturation at 3 and clear-over-increment priority
        for (int i = 0; i < 5; i++) step("sat", 4'b0001, 4'b0001, 1'b1, 1'b0);
        step("clrpri", 4'b1111, 4'b1111, 1'b1, 1'b1);
        step("novld", 4'b1111, 4'b1111, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            step("rnd", W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset mid-stream
        step("pre", 4'b1111, 4'b0111, 1'b1, 1'b0);
        @(negedge clk);
        a = 4'b0110; b = 4'b0011; in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.ov", 32'(out_valid), 32'h0);
        check("arst.cnt", 32'(carry_cnt), 32'h0);
`ifdef HA_RTL_REG_OUT_EN
        check("arst.s", 32'(s), 32'h0);
        check("arst.c", 32'(c), 32'h0);
`else
        check("arst.s", 32'(s), 32'(4'b0101));
        check("arst.c", 32'(c), 32'(4'b0010));
`endif
        @(posedge clk);
        #1;
        check("arst.hold.ov", 32'(out_valid), 32'h0);
        check("arst.hold.cnt", 32'(carry_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        model_reset();
        step("post0", 4'b1010, 4'b1000, 1'b1, 1'b0);
        step("post1", 4'b0011, 4'b0101, 1'b0, 1'b0);
        step("post2", 4'b1111, 4'b0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
